rresp_collect: RTL
==================

// Module: rresp_collect
// PURPOSE
//   Upstream feeder for the read-response line update stage. Slave on the AXI R channel.
//   Packs DATA_W-bit read beats into one LINE_W-bit line, tracking the slice index.
//   Presents the completed line with valid/ready handshake, plus ID, beat count and error status.
//   Sits between the AXI read master port and the line-update/buffer logic.
// PARAMETERS
//   DATA_W   16    width of one R beat (rdata)
//   LINE_W   256   width of assembled line; LINE_W % DATA_W == 0
//   BEATS    LINE_W/DATA_W (16)   slices per line; derived, do not override
//   ID_W     4     width of rid / line_id
// PORTS
//   clk         in   1          single clock, rising edge
//   rst_n       in   1          asynchronous, active-low reset
//   rvalid      in   1          AXI R beat valid
//   rready      out  1          AXI R beat ready
//   rdata       in   DATA_W     AXI R beat data
//   rresp       in   2          AXI R response (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR)
//   rlast       in   1          last beat of burst
//   rid         in   ID_W       transaction ID
//   line_vld    out  1          assembled line valid
//   line_rdy    in   1          consumer accepts line
//   line_data   out  LINE_W     assembled line; beat k in bits [k*DATA_W +: DATA_W]
//   line_id     out  ID_W       rid captured on first beat of the line
//   line_beats  out  clog2(BEATS)+1   number of beats written (1..BEATS)
//   line_err    out  1          any SLVERR/DECERR, rid mismatch, or missing rlast
// BEHAVIOUR
//   Reset (rst_n low, async): state=COLLECT, cnt=0, line_data=0, line_id=0, line_beats=0,
//     line_err=0, line_vld=0, rready=0. rready rises on the first clk edge after reset release.
//   States: COLLECT (rready=1, line_vld=0) and HOLD (rready=0, line_vld=1).
//   Beat accept = rvalid & rready. On accept in COLLECT:
//     - line_data[cnt*DATA_W +: DATA_W] <= rdata; cnt <= cnt+1; line_beats <= cnt+1.
//     - cnt==0: line_id <= rid. cnt!=0 and rid!=line_id: line_err <= 1.
//     - rresp[1]==1: line_err <= 1 (sticky for this line).
//     - rlast==1: go to HOLD. Slices not written keep 0 (short line, line_beats < BEATS).
//     - cnt==BEATS-1 and rlast==0: go to HOLD with line_err <= 1. The next beats of that burst
//       start a new line; this is the defined overflow behaviour.
//   HOLD: line_vld=1 and line_* outputs stay stable until line_rdy=1.
//     On line_vld & line_rdy: next cycle state=COLLECT, cnt=0, line_data=0, line_err=0,
//     line_beats=0.
//   Latency: line_vld rises 1 cycle after the accepting edge of the final beat.
//     Handoff costs 1 bubble: rready=1 again 1 cycle after line handshake, no bypass.
//   rready depends only on state (registered). It never combinationally depends on rvalid.
//   line_rdy while line_vld=0 is ignored. rvalid while rready=0 is held by the AXI master,
//     per AXI rules.
//   Reset mid-line or mid-HOLD: partial line discarded, all outputs return to reset values.
//   cnt width clog2(BEATS). It never wraps past BEATS-1 because the block transitions to HOLD.
// TESTING
//   1. 16-beat burst, rdata=beat index k, rresp=0, rlast on beat 15, rid=3 -> line_vld next cycle;
//      line_data slice k == k; line_id=3; line_beats=16; line_err=0.
//   2. line_rdy held 0 for 5 cycles in HOLD -> rready=0, outputs stable.
//      Then line_rdy=1 -> rready=1 one cycle later, line_data=0.
//   3. 4-beat burst with rlast on beat 3 -> line_beats=4, slices 4..15 == 0, line_err=0.
//   4. Beat 2 with rresp=2'b10 -> line_err=1 at line_vld; the next line has line_err=0.
//   5. 16 beats without rlast, then 2 more beats with rlast -> first line line_err=1,
//      line_beats=16; second line line_beats=2, line_err=0.
//   6. Assert rst_n=0 after beat 7 of a burst -> all outputs 0 asynchronously.
//      A fresh burst after release assembles correctly from slice 0.

Source files
------------

// File: rtl/rresp_collect_if.sv
// Signal bundle between the AXI R channel master, the line collector and the line consumer.
// The collector takes the slave view; the bench and surrounding logic take the master view.
interface rresp_collect_if #(
    parameter int DATA_W = 16,
    parameter int LINE_W = 256,
    parameter int ID_W   = 4,
    parameter int BCNT_W = $clog2(LINE_W / DATA_W) + 1
);
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;
    logic              line_vld;
    logic              line_rdy;
    logic [LINE_W-1:0] line_data;
    logic [ID_W-1:0]   line_id;
    logic [BCNT_W-1:0] line_beats;
    logic              line_err;

    modport slave (
        input  rvalid, rdata, rresp, rlast, rid, line_rdy,
        output rready, line_vld, line_data, line_id, line_beats, line_err
    );

    modport master (
        output rvalid, rdata, rresp, rlast, rid, line_rdy,
        input  rready, line_vld, line_data, line_id, line_beats, line_err
    );
endinterface

// File: rtl/rresp_collect.sv
// Packs AXI R beats into one line and hands it to the consumer with ID, beat count and error flag.
// Two states: COLLECT accepts beats, HOLD presents the finished line until it is taken.
module rresp_collect #(
    parameter int DATA_W = 16,
    parameter int LINE_W = 256,
    parameter int ID_W   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rresp_collect_if.slave bus
);
    localparam int BEATS  = LINE_W / DATA_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int BCNT_W = CNT_W + 1;

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rdy_q;
    logic              vld_q;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] data_q;
    logic [ID_W-1:0]   id_q;
    logic [BCNT_W-1:0] beats_q;
    logic              err_q;

    logic accept;
    logic take;
    logic last_slot;
    logic beat_err;

    // rready and line_vld are registered copies of the next state, so the
    // R channel never sees a combinational path from rvalid back to rready.
    assign accept    = bus.rvalid & rdy_q & (state == COLLECT);
    assign take      = vld_q & bus.line_rdy;
    assign last_slot = (cnt == CNT_W'(BEATS - 1));
    assign beat_err  = (bus.rresp == 2'b10) || (bus.rresp == 2'b11)
                     || ((cnt != '0) && (bus.rid != id_q))
                     || (last_slot && !bus.rlast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            rdy_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt == COLLECT);
            vld_q <= (state_nxt == HOLD);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && (bus.rlast || last_slot)) state_nxt = HOLD;
            HOLD:    if (take) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // A full line without rlast closes here with the error flag; the rest of
    // that burst opens a new line after the handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            data_q  <= '0;
            id_q    <= '0;
            beats_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            data_q[cnt*DATA_W +: DATA_W] <= bus.rdata;
            beats_q <= {1'b0, cnt} + BCNT_W'(1);
            err_q   <= err_q | beat_err;
            if (cnt == '0) id_q <= bus.rid;
            if (!last_slot) cnt <= cnt + CNT_W'(1);
        end else if (take) begin
            cnt     <= '0;
            data_q  <= '0;
            beats_q <= '0;
            err_q   <= 1'b0;
        end
    end

    assign bus.rready     = rdy_q;
    assign bus.line_vld   = vld_q;
    assign bus.line_data  = data_q;
    assign bus.line_id    = id_q;
    assign bus.line_beats = beats_q;
    assign bus.line_err   = err_q;
endmodule
